// File: rtl/superio_pkg.sv
// Shared definitions for the super-I/O external bus: FSM states, window
// offsets inside the $E600 I/O page and the idle-read value.
package superio_pkg;

  // Bus-initiator transaction states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } bus_state_e;

  // Peripheral window offsets inside the I/O page
  localparam logic [7:0] VPU_OFS      = 8'h00;
  localparam logic [7:0] SIMPLEIO_OFS = 8'hA0;
  localparam logic [7:0] PSG_OFS      = 8'hB0;
  localparam logic [7:0] SPIIO_OFS    = 8'hC0;
  localparam logic [7:0] PS2IO_OFS    = 8'hD0;

  // Value returned by unmapped reads
  localparam logic [7:0] IDLE_READ_VAL = 8'hA5;

endpackage

// File: rtl/io_bus_master_if.sv
// Command port plus 6303-style external bus. The master modport is the
// bus initiator's view; the slave modport is the requester/peripheral side.
interface io_bus_master_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       ack;
  logic [7:0] rdata;
  logic       E;
  logic       EXTCS;
  logic       RW;
  logic [7:0] ADDR;
  logic [7:0] DATA_out;
  logic       DATA_oe;
  logic [7:0] DATA_in;

  modport master (
    input  req, we, addr, wdata, DATA_in,
    output busy, ack, rdata, E, EXTCS, RW, ADDR, DATA_out, DATA_oe
  );

  modport slave (
    output req, we, addr, wdata, DATA_in,
    input  busy, ack, rdata, E, EXTCS, RW, ADDR, DATA_out, DATA_oe
  );
endinterface

// File: rtl/io_bus_master_sync2.sv
// Parameterized two-flop synchronizer with synchronous active-low clear.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/io_bus_master.sv
// Bus initiator for the 6303-style I/O bus: free-running E generator and a
// request/ack command FSM that phases EXTCS/RW/ADDR/DATA around E.
module io_bus_master
  import superio_pkg::*;
#(
  parameter int E_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  io_bus_master_if.master  bus,
  input  logic [1:0]       IRQ_n,
  input  logic             NMI_n,
  output logic [1:0]       irq,
  output logic             nmi
);

  localparam int ECW = (E_DIV > 2) ? $clog2(E_DIV) : 1;
  localparam logic [ECW-1:0] ECNT_LAST = ECW'(E_DIV - 1);

  logic [ECW-1:0] ecnt_r;
  logic           e_r;
  logic           e_last_s, fall_s, rise_s;

  bus_state_e state_r, state_s;

  logic       we_r, we_s;
  logic [7:0] addr_r, addr_s, wdata_r, wdata_s;
  logic       busy_r, busy_s, ack_r, ack_s;
  logic [7:0] rdata_r, rdata_s;
  logic       extcs_r, extcs_s, rw_r, rw_s, doe_r, doe_s;
  logic [7:0] badr_r, badr_s, dout_r, dout_s;

  assign e_last_s = (ecnt_r == ECNT_LAST);
  assign fall_s   = e_last_s & e_r;
  assign rise_s   = e_last_s & ~e_r;

  // Free-running E divider, independent of bus activity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ecnt_r <= {ECW{1'b0}};
      e_r    <= 1'b0;
    end else if (e_last_s) begin
      ecnt_r <= {ECW{1'b0}};
      e_r    <= ~e_r;
    end else begin
      ecnt_r <= ecnt_r + ECW'(1);
      e_r    <= e_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic: bus phases are tied to E fall/rise events
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.req) state_s = ARM;  else state_s = IDLE;
      ARM:     if (fall_s)  state_s = LOW;  else state_s = ARM;
      LOW:     if (rise_s)  state_s = HIGH; else state_s = LOW;
      HIGH:    if (fall_s)  state_s = IDLE; else state_s = HIGH;
      default: state_s = IDLE;
    endcase
  end

  // FSM output logic: next values for every registered output
  always_comb begin
    we_s    = we_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    busy_s  = busy_r;
    ack_s   = 1'b0;
    rdata_s = rdata_r;
    extcs_s = extcs_r;
    rw_s    = rw_r;
    doe_s   = doe_r;
    badr_s  = badr_r;
    dout_s  = dout_r;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          we_s    = bus.we;
          addr_s  = bus.addr;
          wdata_s = bus.wdata;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      ARM: begin
        if (fall_s) begin
          badr_s  = addr_r;
          extcs_s = 1'b0;
          rw_s    = ~we_r;
          // Drive DATA only for writes so it never fights a read driver
          if (we_r) begin
            dout_s = wdata_r;
            doe_s  = 1'b1;
          end else begin
            doe_s  = 1'b0;
          end
        end else begin
          extcs_s = 1'b1;
        end
      end
      LOW: begin
        busy_s = 1'b1;
      end
      HIGH: begin
        if (fall_s) begin
          if (!we_r) begin
            rdata_s = bus.DATA_in;
          end else begin
            rdata_s = rdata_r;
          end
          extcs_s = 1'b1;
          rw_s    = 1'b1;
          doe_s   = 1'b0;
          ack_s   = 1'b1;
          busy_s  = 1'b0;
        end else begin
          busy_s  = 1'b1;
        end
      end
      default: begin
        extcs_s = 1'b1;
        rw_s    = 1'b1;
        doe_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Registered command-port and bus outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
      rdata_r <= 8'h00;
      extcs_r <= 1'b1;
      rw_r    <= 1'b1;
      doe_r   <= 1'b0;
      badr_r  <= 8'h00;
      dout_r  <= 8'h00;
    end else begin
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      busy_r  <= busy_s;
      ack_r   <= ack_s;
      rdata_r <= rdata_s;
      extcs_r <= extcs_s;
      rw_r    <= rw_s;
      doe_r   <= doe_s;
      badr_r  <= badr_s;
      dout_r  <= dout_s;
    end
  end

  assign bus.E        = e_r;
  assign bus.busy     = busy_r;
  assign bus.ack      = ack_r;
  assign bus.rdata    = rdata_r;
  assign bus.EXTCS    = extcs_r;
  assign bus.RW       = rw_r;
  assign bus.ADDR     = badr_r;
  assign bus.DATA_out = dout_r;
  assign bus.DATA_oe  = doe_r;

  // Inversion sits ahead of the synchronizer so cleared flops mean "no interrupt"
  logic [1:0] irq_raw_s;
  logic       nmi_raw_s;
  assign irq_raw_s = ~IRQ_n;
  assign nmi_raw_s = ~NMI_n;

  sync2 #(.W(2)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_raw_s),
    .q     (irq)
  );

  sync2 #(.W(1)) u_nmi_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (nmi_raw_s),
    .q     (nmi)
  );

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master (E_DIV=4): scoreboard of expected
// completions plus a bus monitor and a small peripheral model.
module tb_io_bus_master;

  logic       clk;
  logic       rst_n;
  logic [1:0] IRQ_n;
  logic       NMI_n;
  logic [1:0] irq;
  logic       nmi;

  io_bus_master_if bus ();

  io_bus_master #(.E_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .IRQ_n (IRQ_n),
    .NMI_n (NMI_n),
    .irq   (irq),
    .nmi   (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  txn_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ack_cnt  = 0;
  logic [7:0] last_rd = 8'h00;
  logic [7:0] p_wr_addr = 8'h00;
  logic [7:0] p_wr_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] periph_read(input logic [7:0] a);
    if (a == 8'hE0) return 8'hA5;
    return a ^ 8'h3C;
  endfunction

  // Peripheral model: returns read data while selected, latches writes on E rise
  assign bus.DATA_in = (!bus.EXTCS && bus.RW) ? periph_read(bus.ADDR) : 8'hFF;

  always @(posedge bus.E) begin
    if (rst_n && !bus.EXTCS && !bus.RW && bus.DATA_oe) begin
      p_wr_addr <= bus.ADDR;
      p_wr_data <= bus.DATA_out;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_txn(input logic w, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    if (!w) last_rd = periph_read(a);
    t.rdata = last_rd;
    sbq.push_back(t);
  endtask

  // Called at a negedge; presents one request and removes it after acceptance
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("busy_timeout", 32'd0, 32'd1);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    push_txn(w, a, d);
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  task automatic wait_ack(output int at_cyc);
    int n = 0;
    at_cyc = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.ack === 1'b1) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check_eq("ack_timeout", 32'd0, 32'd1);
  endtask

  // Bus monitor: CS width/gap, DATA_oe vs RW, ack pulse and scoreboard pop
  int   lo_cnt = 0, hi_cnt = 0;
  logic prev_cs = 1'b1, prev_ack = 1'b0, seen_txn = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lo_cnt = 0; hi_cnt = 0; prev_cs = 1'b1; prev_ack = 1'b0; seen_txn = 1'b0;
      end else begin
        if (bus.DATA_oe === 1'b1) check_eq("oe_while_rw", 32'(bus.RW), 32'd0);
        if (bus.EXTCS === 1'b0) begin
          if (prev_cs) begin
            if (seen_txn) check_eq("cs_gap_ge8", 32'(hi_cnt >= 8), 32'd1);
            lo_cnt = 0;
          end
          lo_cnt++;
        end else begin
          if (!prev_cs) begin
            check_eq("cs_low_width", 32'(lo_cnt), 32'd8);
            seen_txn = 1'b1;
            hi_cnt = 0;
          end
          hi_cnt++;
        end
        prev_cs = bus.EXTCS;
        if (bus.ack === 1'b1) begin
          ack_cnt++;
          check_eq("ack_one_cycle", 32'(prev_ack), 32'd0);
          check_eq("ack_has_txn", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            txn_t t;
            t = sbq.pop_front();
            check_eq("rdata", 32'(bus.rdata), 32'(t.rdata));
            if (t.we) begin
              check_eq("periph_waddr", 32'(p_wr_addr), 32'(t.addr));
              check_eq("periph_wdata", 32'(p_wr_data), 32'(t.wdata));
            end
          end
        end
        prev_ack = bus.ack;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, n, acks0;
    bit found;
    rst_n = 1'b0; IRQ_n = 2'b11; NMI_n = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;

    // Reset values
    repeat (5) @(negedge clk);
    check_eq("rst_E", 32'(bus.E), 32'd0);
    check_eq("rst_EXTCS", 32'(bus.EXTCS), 32'd1);
    check_eq("rst_RW", 32'(bus.RW), 32'd1);
    check_eq("rst_DATA_oe", 32'(bus.DATA_oe), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
    check_eq("rst_ADDR", 32'(bus.ADDR), 32'd0);
    check_eq("rst_DATA_out", 32'(bus.DATA_out), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_nmi", 32'(nmi), 32'd0);

    // E toggles every 4 clk after release
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check_eq("e_toggle", 32'(bus.E), 32'((k / 4) % 2));
    end

    // Interrupt synchronizer latency
    IRQ_n = 2'b10; NMI_n = 1'b0;
    @(negedge clk);
    check_eq("irq_1clk", 32'(irq), 32'd0);
    check_eq("nmi_1clk", 32'(nmi), 32'd0);
    @(negedge clk);
    check_eq("irq_2clk", 32'(irq), 32'd1);
    check_eq("nmi_2clk", 32'(nmi), 32'd1);
    IRQ_n = 2'b01; NMI_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("irq_swap", 32'(irq), 32'd2);
    check_eq("nmi_clear", 32'(nmi), 32'd0);
    IRQ_n = 2'b11;

    // Write 0x55 to 0xA0: bus phase at fall event
    @(negedge clk);
    issue(1'b1, 8'hA0, 8'h55);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.EXTCS === 1'b0) found = 1'b1;
    end
    check_eq("wr_cs_seen", 32'(found), 32'd1);
    check_eq("wr_E_fell", 32'(bus.E), 32'd0);
    check_eq("wr_RW", 32'(bus.RW), 32'd0);
    check_eq("wr_ADDR", 32'(bus.ADDR), 32'hA0);
    check_eq("wr_DATA_out", 32'(bus.DATA_out), 32'h55);
    check_eq("wr_DATA_oe", 32'(bus.DATA_oe), 32'd1);
    wait_ack(a1);

    // Read 0xE0 returns 0xA5
    @(negedge clk);
    issue(1'b0, 8'hE0, 8'h00);
    wait_ack(a1);
    @(negedge clk);
    check_eq("rd_rdata_hold", 32'(bus.rdata), 32'hA5);

    // Write after read: rdata must be held
    issue(1'b1, 8'hC3, 8'h3A);
    wait_ack(a1);

    // Back-to-back: req held high, write 0xB0 then read 0xB1
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'hB0; bus.wdata = 8'h99;
    push_txn(1'b1, 8'hB0, 8'h99);
    @(posedge clk);
    #1 bus.we = 1'b0; bus.addr = 8'hB1; bus.wdata = 8'h00;
    push_txn(1'b0, 8'hB1, 8'h00);
    wait_ack(a1);
    @(posedge clk);
    #1 bus.req = 1'b0;
    wait_ack(a2);
    check_eq("b2b_gap_le16", 32'((a2 - a1) <= 16 && (a2 - a1) >= 9), 32'd1);
    check_eq("b2b_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset while in HIGH: no ack for the aborted read
    @(negedge clk);
    issue(1'b0, 8'hD0, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.EXTCS === 1'b0 && bus.E === 1'b1) found = 1'b1;
    end
    check_eq("high_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_EXTCS", 32'(bus.EXTCS), 32'd1);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_ack", 32'(bus.ack), 32'd0);
    sbq.delete();
    last_rd = 8'h00;
    @(negedge clk);
    acks0 = ack_cnt;
    rst_n = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("no_ack_after_rst", 32'(ack_cnt - acks0), 32'd0);
    check_eq("post_rst_rdata", 32'(bus.rdata), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
